// File: rtl/router_input_port_if.sv
// router_input_port_if: link bundle for one NoC router input port
//   slave : the input port itself (takes rx/data_i/grant_i/credit_i, drives the rest)
//   master: the surrounding neighbour link, arbiter and crossbar
//   rx/data_i/credit_o   upstream flit link with credit back-pressure
//   req_o/grant_i        one-hot route request {LOCAL,SOUTH,NORTH,WEST,EAST} and grant
//   release_o            path-free pulse at end of packet
//   tx/data_o/credit_i   downstream flit link
//   count_o              buffer occupancy
interface router_input_port_if #(
  parameter int FLIT_WIDTH   = 16,
  parameter int BUFFER_DEPTH = 16
);
  localparam int CW = $clog2(BUFFER_DEPTH) + 1;
  logic                  rx;
  logic [FLIT_WIDTH-1:0] data_i;
  logic                  credit_o;
  logic [4:0]            req_o;
  logic                  grant_i;
  logic                  release_o;
  logic                  tx;
  logic [FLIT_WIDTH-1:0] data_o;
  logic                  credit_i;
  logic [CW-1:0]         count_o;
  modport master(output rx, data_i, grant_i, credit_i,
                 input credit_o, req_o, release_o, tx, data_o, count_o);
  modport slave(input rx, data_i, grant_i, credit_i,
                output credit_o, req_o, release_o, tx, data_o, count_o);
endinterface

// File: rtl/router_input_port.sv
// router_input_port: credit-based NoC input port; buffers flits, XY-routes the header, forwards a packet
//   clock, reset  sole clock; asynchronous active-high reset
//   p (slave)     flit link in/out, route request/grant/release, occupancy
module router_input_port #(
  parameter int                    FLIT_WIDTH   = 16,
  parameter int                    BUFFER_DEPTH = 16,
  parameter logic [FLIT_WIDTH-1:0] ADDRESS      = '0
) (
  input logic          clock,
  input logic          reset,
  router_input_port_if.slave p
);
  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int HW = FLIT_WIDTH / 2;
  typedef enum logic [2:0] {IDLE, ROUTE, WAIT_GRANT, SEND_HDR, SEND_SIZE, SEND_PAYLOAD, DONE} state_t;
  state_t                state;
  logic [FLIT_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic [FLIT_WIDTH-1:0] remaining;
  logic [HW-1:0]         dx, dy;
  logic [4:0]            route;
  logic                  full, empty, sending, wr, rd, last;
  // depth is a power of two, so the occupancy MSB alone marks full
  assign full       = count[AW];
  assign empty      = count == '0;
  assign sending    = state == SEND_HDR || state == SEND_SIZE || state == SEND_PAYLOAD;
  assign p.credit_o = !reset && !full;
  assign p.tx       = sending && !empty;
  assign p.data_o   = mem[rd_ptr];
  assign p.count_o  = count;
  assign wr         = p.rx && p.credit_o;
  assign rd         = p.tx && p.credit_i;
  assign dx         = p.data_o[FLIT_WIDTH-1:HW];
  assign dy         = p.data_o[HW-1:0];
  assign route      = dx > ADDRESS[FLIT_WIDTH-1:HW] ? 5'b00001 :
                      dx < ADDRESS[FLIT_WIDTH-1:HW] ? 5'b00010 :
                      dy > ADDRESS[HW-1:0]          ? 5'b00100 :
                      dy < ADDRESS[HW-1:0]          ? 5'b01000 : 5'b10000;
  // final flit of the packet leaves this cycle: a zero size flit, or the payload flit read at counter 1
  assign last       = rd && (state == SEND_SIZE ? p.data_o == '0 :
                             state == SEND_PAYLOAD && remaining == FLIT_WIDTH'(1));
  always_ff @(posedge clock)
    if (wr) mem[wr_ptr] <= p.data_i;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state       <= IDLE;
      p.req_o     <= '0;
      p.release_o <= 1'b0;
      remaining   <= '0;
    end else begin
      p.release_o <= 1'b0;
      case (state)
        IDLE:         if (!empty) state <= ROUTE;
        ROUTE:        begin p.req_o <= route; state <= WAIT_GRANT; end
        WAIT_GRANT:   if (p.grant_i) state <= SEND_HDR;
        SEND_HDR:     if (rd) state <= SEND_SIZE;
        SEND_SIZE:    if (rd) begin remaining <= p.data_o; state <= SEND_PAYLOAD; end
        SEND_PAYLOAD: if (rd) remaining <= remaining - 1'b1;
        default:      state <= IDLE;
      endcase
      // request drops together with the release pulse so the arbiter sees the path freed in DONE
      if (last) begin
        state       <= DONE;
        p.req_o     <= '0;
        p.release_o <= 1'b1;
      end
    end
endmodule
